xrv_mdu_seq: RTL and testbench

Sequential RV32M multiply/divide responder for the xriscv execute stage. It accepts one M-extension operation per request over a valid/ready handshake and computes it iteratively, one bit per cycle. It returns the 32-bit result over a second valid/ready handshake and gives RISC-V-defined results for divide-by-zero and signed overflow. It is the single unit behind the core's mul/div issue port and replaces separate mult and div instances.

---
 rtl/xrv_mdu_seq.sv | 128 ++++++++++++
 tb/tb_xrv_mdu_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xrv_mdu_seq.sv
// Sequential RV32M multiply/divide unit: one operand bit per cycle, 32 iterations per op.
// Divide-by-zero and signed overflow are resolved at accept time without iterating.
module xrv_mdu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        kill,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  optype,
    output logic [31:0] result,
    output logic        result_valid,
    input  logic        result_ready
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [2:0]  op;
    logic        neg_q, neg_r;
    logic [31:0] hi, lo, mag_b;

    logic        accept, sign_a, sign_b, neg_a, neg_b, special;
    logic [31:0] mag_a_in, mag_b_in, special_res;
    logic [32:0] mul_sum, rem_sh, diff;
    logic [31:0] hi_nxt, lo_nxt, quo, rem;
    logic [63:0] prod;
    logic [31:0] final_res;

    // Operand decode: signedness follows funct3, magnitudes feed the unsigned core
    always_comb begin
        accept   = in_valid & in_ready & ~kill;
        sign_a   = (optype == 3'd1) | (optype == 3'd2) | (optype == 3'd4) | (optype == 3'd6);
        sign_b   = (optype == 3'd1) | (optype == 3'd4) | (optype == 3'd6);
        neg_a    = sign_a & a[31];
        neg_b    = sign_b & b[31];
        mag_a_in = neg_a ? -a : a;
        mag_b_in = neg_b ? -b : b;
        special  = optype[2] & ((b == 32'd0) |
                   (~optype[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF)));
        if (b == 32'd0)
            special_res = optype[1] ? a : 32'hFFFF_FFFF;
        else
            special_res = optype[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration: lo holds the multiplier (then product low) or the dividend (then quotient)
    always_comb begin
        mul_sum = lo[0] ? ({1'b0, hi} + {1'b0, mag_b}) : {1'b0, hi};
        rem_sh  = {hi, lo[31]};
        diff    = rem_sh - {1'b0, mag_b};
        if (op[2]) begin
            hi_nxt = diff[32] ? rem_sh[31:0] : diff[31:0];
            lo_nxt = {lo[30:0], ~diff[32]};
        end else begin
            hi_nxt = mul_sum[32:1];
            lo_nxt = {mul_sum[0], lo[31:1]};
        end
        prod = {hi_nxt, lo_nxt};
        if (neg_q)
            prod = -prod;
        quo = neg_q ? -lo_nxt : lo_nxt;
        rem = neg_r ? -hi_nxt : hi_nxt;
        if (op[2])
            final_res = op[1] ? rem : quo;
        else
            final_res = (op == 3'd0) ? prod[31:0] : prod[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = special ? DONE : CALC;
                CALC:    if (cnt == 6'd31) state_nxt = DONE;
                DONE:    if (result_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state == IDLE) & ~rst;
        result_valid = (state == DONE);
    end

    // The last iteration's edge also applies the sign fix and loads the result
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 6'd0;
            op     <= 3'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            mag_b  <= 32'd0;
            result <= 32'd0;
        end else if (accept) begin
            cnt   <= 6'd0;
            op    <= optype;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            hi    <= 32'd0;
            lo    <= mag_a_in;
            mag_b <= mag_b_in;
            if (special)
                result <= special_res;
        end else if ((state == CALC) && !kill) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31)
                result <= final_res;
        end
    end

endmodule

// File: tb/tb_xrv_mdu_seq.sv
// Self-checking bench for xrv_mdu_seq: directed corner cases plus randomized ops
// compared against a plain-arithmetic RV32M reference model.
module tb_xrv_mdu_seq;

    logic        clk = 1'b0;
    logic        rst, kill, in_valid, in_ready;
    logic [31:0] a, b, result;
    logic [2:0]  optype;
    logic        result_valid, result_ready;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    xrv_mdu_seq dut (
        .clk(clk), .rst(rst), .kill(kill),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .optype(optype),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int          sx, sy;
        longint      p;
        logic [63:0] pu;
        logic        ovf;
        sx  = $signed(x);
        sy  = $signed(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (op)
            3'd0: return x * y;
            3'd1: begin p = longint'(sx) * longint'(sy); pu = p; return pu[63:32]; end
            3'd2: begin p = longint'(sx) * longint'({32'd0, y}); pu = p; return pu[63:32]; end
            3'd3: begin pu = {32'd0, x} * {32'd0, y}; return pu[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $unsigned(sx / sy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'd0;
                return $unsigned(sx % sy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Waits for in_ready and returns just after the accept edge
    task automatic startOp(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        optype   = op;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        optype   = 3'($urandom);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int hold);
        int          lat = 0;
        logic [31:0] exp;
        bit          special;
        exp     = refModel(op, x, y);
        special = op[2] && ((y == 0) || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
        startOp(op, x, y);
        @(negedge clk);
        checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
        while (!result_valid && lat < 40) begin
            result_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        result_ready = 1'b0;
        checkOutput($sformatf("latency op%0d", op), 32'(lat), special ? 32'd0 : 32'd32);
        checkOutput($sformatf("result op%0d a=%08h b=%08h", op, x, y), result, exp);
        repeat (hold) begin
            @(negedge clk);
            checkOutput("hold_result", result, exp);
            checkOutput("hold_valid", {31'd0, result_valid}, 32'd1);
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after", {31'd0, in_ready}, 32'd1);
        checkOutput("valid_drop", {31'd0, result_valid}, 32'd0);
    endtask

    task automatic expectNoResult(input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        checkOutput("no_result_after_abort", 32'(seen), 32'd0);
    endtask

    initial begin
        rst = 1'b1; kill = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
        a = 32'd0; b = 32'd0; optype = 3'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("reset_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        applyStimulus(3'd5, 32'hFFFF_FFFF, 32'd2, 10);
        applyStimulus(3'd7, 32'd100, 32'd7, 0);
        applyStimulus(3'd4, 32'd5, 32'd0, 0);
        applyStimulus(3'd6, 32'd5, 32'd0, 3);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // kill lands on the tenth iteration edge after accept
        startOp(3'd0, 32'd12345, 32'd678);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        checkOutput("kill_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("kill_in_ready", {31'd0, in_ready}, 32'd1);
        expectNoResult(40);
        applyStimulus(3'd3, 32'd3, 32'd5, 0);

        startOp(3'd4, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rst_mid_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_in_ready_after", {31'd0, in_ready}, 32'd1);
        expectNoResult(40);
        applyStimulus(3'd3, 32'd3, 32'd5, 0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  op;
            logic [31:0] x, y;
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = $urandom_range(0, 300) - 150; y = $urandom_range(0, 20) - 10; end
                default: ;
            endcase
            applyStimulus(op, x, y, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
